uart_status_tx: RTL and testbench

Transmit-side companion to the glitcher's UART command receiver. On request, it snapshots the live pulse configuration (delay, width, pulse count, spacing) and pulser status, then serialises it as a fixed-format reply frame on the UART TX line as 8N1 bytes. It sits inside the glitch controller between the parameter registers and `uart_tx_o`, so the host can read back what it programmed.

---
 rtl/uart_status_tx.sv | 206 ++++++++++++++++++++
 tb/tb_uart_status_tx.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_status_tx.sv
`default_nettype none
// ============================================================================
// Module   : uart_status_tx
// Purpose  : Status reply transmitter for the glitch controller. On req_i it
//            snapshots the pulse configuration and pulser status, then sends
//            them as a fixed-format 8N1 frame on uart_tx_o.
// Options  : `define UART_STATUS_CHECKSUM_EN appends an XOR checksum byte
//            covering bytes 1..8. The frame is 10 bytes with it, 9 without.
// Revision : 1.0 - initial release
// ============================================================================
module uart_status_tx #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 115200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic [15:0] delay_i,
  input  logic [7:0]  width_i,
  input  logic [7:0]  num_pulses_i,
  input  logic [15:0] spacing_i,
  input  logic        en_i,
  input  logic        ready_i,
  output logic        uart_tx_o,
  output logic        busy_o,
  output logic        done_o
);

  // Bit period in clocks. It must be at least 2, so CNT_W is never zero.
  localparam int              CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int              CNT_W        = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BAUD_LAST   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] BAUD_ONE    = CNT_W'(1);

  localparam logic [7:0] SYNC_BYTE  = 8'h55;
  localparam logic [7:0] REPLY_ID   = 8'h50;

`ifdef UART_STATUS_CHECKSUM_EN
  localparam logic [3:0] LAST_BYTE  = 4'd9;
`else
  localparam logic [3:0] LAST_BYTE  = 4'd8;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] baud_q;
  logic [2:0]       bit_q;
  logic [3:0]       byte_q;

  // Snapshot taken at request time; the whole frame is served from here.
  logic [15:0]      delay_q;
  logic [7:0]       width_q;
  logic [7:0]       num_pulses_q;
  logic [15:0]      spacing_q;
  logic             en_q;
  logic             ready_q;

  logic             tx_q;
  logic             busy_q;
  logic             done_q;

  logic [7:0]       cur_byte;
  logic [7:0]       status_byte;
  logic [2:0]       next_bit;
  logic             baud_end;

  assign status_byte = {6'b000000, ready_q, en_q};
  assign next_bit    = bit_q + 3'd1;
  assign baud_end    = (baud_q == BAUD_LAST);

`ifdef UART_STATUS_CHECKSUM_EN
  logic [7:0] checksum;

  // XOR of every byte after the sync byte.
  always_comb begin
    checksum = REPLY_ID ^ delay_q[15:8] ^ delay_q[7:0] ^ width_q ^
               num_pulses_q ^ spacing_q[15:8] ^ spacing_q[7:0] ^ status_byte;
  end
`endif

  // Select the frame byte currently being shifted out.
  always_comb begin
    cur_byte = 8'h00;
    case (byte_q)
      4'd0:    cur_byte = SYNC_BYTE;
      4'd1:    cur_byte = REPLY_ID;
      4'd2:    cur_byte = delay_q[15:8];
      4'd3:    cur_byte = delay_q[7:0];
      4'd4:    cur_byte = width_q;
      4'd5:    cur_byte = num_pulses_q;
      4'd6:    cur_byte = spacing_q[15:8];
      4'd7:    cur_byte = spacing_q[7:0];
      4'd8:    cur_byte = status_byte;
`ifdef UART_STATUS_CHECKSUM_EN
      4'd9:    cur_byte = checksum;
`endif
      default: cur_byte = 8'h00;
    endcase
  end

  // Frame sequencer: the line level, busy and done are all set on the same
  // edge as the state change so they stay aligned with the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      baud_q       <= '0;
      bit_q        <= 3'd0;
      byte_q       <= 4'd0;
      delay_q      <= 16'h0000;
      width_q      <= 8'h00;
      num_pulses_q <= 8'h00;
      spacing_q    <= 16'h0000;
      en_q         <= 1'b0;
      ready_q      <= 1'b0;
      tx_q         <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          tx_q   <= 1'b1;
          busy_q <= 1'b0;
          if (req_i) begin
            delay_q      <= delay_i;
            width_q      <= width_i;
            num_pulses_q <= num_pulses_i;
            spacing_q    <= spacing_i;
            en_q         <= en_i;
            ready_q      <= ready_i;
            byte_q       <= 4'd0;
            bit_q        <= 3'd0;
            baud_q       <= '0;
            tx_q         <= 1'b0;
            busy_q       <= 1'b1;
            state_q      <= S_START;
          end
        end

        S_START: begin
          if (baud_end) begin
            baud_q  <= '0;
            bit_q   <= 3'd0;
            tx_q    <= cur_byte[0];
            state_q <= S_DATA;
          end else begin
            baud_q <= baud_q + BAUD_ONE;
          end
        end

        S_DATA: begin
          if (baud_end) begin
            baud_q <= '0;
            if (bit_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= S_STOP;
            end else begin
              bit_q <= next_bit;
              tx_q  <= cur_byte[next_bit];
            end
          end else begin
            baud_q <= baud_q + BAUD_ONE;
          end
        end

        S_STOP: begin
          if (baud_end) begin
            baud_q <= '0;
            if (byte_q == LAST_BYTE) begin
              // Last stop bit finished: one idle-high cycle flagged by done.
              tx_q    <= 1'b1;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_IDLE;
            end else begin
              // Next start bit follows the stop bit with no gap.
              byte_q  <= byte_q + 4'd1;
              tx_q    <= 1'b0;
              state_q <= S_START;
            end
          end else begin
            baud_q <= baud_q + BAUD_ONE;
          end
        end

        default: begin
          state_q <= S_IDLE;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign uart_tx_o = tx_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_status_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_status_tx
// Purpose  : Self-checking bench for uart_status_tx. Records the output lines
//            every cycle and compares them with a byte-level frame model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_status_tx;

  localparam int C  = 10;      // clocks per bit for 1 MHz / 100 kbaud
  localparam int TR = 16384;   // trace depth in cycles
`ifdef UART_STATUS_CHECKSUM_EN
  localparam int NB = 10;
`else
  localparam int NB = 9;
`endif
  localparam int FLEN = NB * 10 * C;

  logic        clk;
  logic        rst;
  logic        req;
  logic [15:0] delay;
  logic [7:0]  width;
  logic [7:0]  num_pulses;
  logic [15:0] spacing;
  logic        en;
  logic        ready;
  logic        uart_tx;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  logic tx_tr   [0:TR-1];
  logic busy_tr [0:TR-1];
  logic done_tr [0:TR-1];

  logic [7:0] exp_b [0:9];

  uart_status_tx #(
    .CLK_FREQ  (1_000_000),
    .BAUD_RATE (100_000)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_i        (req),
    .delay_i      (delay),
    .width_i      (width),
    .num_pulses_i (num_pulses),
    .spacing_i    (spacing),
    .en_i         (en),
    .ready_i      (ready),
    .uart_tx_o    (uart_tx),
    .busy_o       (busy),
    .done_o       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter: after rising edge k, cyc equals k.
  always @(posedge clk) cyc <= cyc + 1;

  // Trace index k holds the outputs produced by rising edge k.
  always @(negedge clk) begin
    if (cyc < TR) begin
      tx_tr[cyc]   <= uart_tx;
      busy_tr[cyc] <= busy;
      done_tr[cyc] <= done;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Leaves the bench just after edge k-1, so anything driven now is sampled at edge k.
  task automatic wait_to(input int k);
    while (cyc < k - 1) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_inputs(input logic [15:0] d, input logic [7:0] w, input logic [7:0] n,
                            input logic [15:0] sp, input logic e, input logic r);
    delay = d; width = w; num_pulses = n; spacing = sp; en = e; ready = r;
  endtask

  task automatic set_random_inputs();
    set_inputs(16'($urandom), 8'($urandom), 8'($urandom), 16'($urandom),
               1'($urandom), 1'($urandom));
  endtask

  // Reference frame: byte list straight from the reply format.
  task automatic model_frame(input logic [15:0] d, input logic [7:0] w, input logic [7:0] n,
                             input logic [15:0] sp, input logic e, input logic r);
    logic [7:0] x;
    exp_b[0] = 8'h55;
    exp_b[1] = 8'h50;
    exp_b[2] = d[15:8];
    exp_b[3] = d[7:0];
    exp_b[4] = w;
    exp_b[5] = n;
    exp_b[6] = sp[15:8];
    exp_b[7] = sp[7:0];
    exp_b[8] = {6'b0, r, e};
    x = 8'h00;
    for (int i = 1; i <= 8; i++) x = x ^ exp_b[i];
    exp_b[9] = x;
  endtask

  // Pulse req for one cycle; s is the first trace index of the frame.
  task automatic pulse_req(output int s);
    s = cyc + 1;
    req = 1'b1;
    @(posedge clk);
    #1;
    req = 1'b0;
  endtask

  // Compare a whole frame starting at trace index s against exp_b.
  task automatic check_frame(input int s, input string tag);
    int wave_err, busy_err, done_err, k, bp;
    logic lvl;
    logic [7:0] b;
    wait_to(s + FLEN + 3);
    wave_err = 0; busy_err = 0; done_err = 0;
    for (int i = 0; i < FLEN; i++) begin
      k  = i / (10 * C);
      bp = (i % (10 * C)) / C;
      if (bp == 0)      lvl = 1'b0;
      else if (bp == 9) lvl = 1'b1;
      else              lvl = exp_b[k][bp - 1];
      if (tx_tr[s + i] !== lvl)  wave_err++;
      if (busy_tr[s + i] !== 1'b1) busy_err++;
      if (done_tr[s + i] !== 1'b0) done_err++;
    end
    check({tag, " wave"}, wave_err, 0);
    check({tag, " busy"}, busy_err, 0);
    check({tag, " early done"}, done_err, 0);
    check({tag, " done pulse"}, done_tr[s + FLEN], 1);
    check({tag, " busy at done"}, busy_tr[s + FLEN], 0);
    check({tag, " tx at done"}, tx_tr[s + FLEN], 1);
    check({tag, " done width"}, done_tr[s + FLEN + 1], 0);
    // Mid-bit sampling decoder.
    for (int j = 0; j < NB; j++) begin
      for (int t = 0; t < 8; t++) b[t] = tx_tr[s + j * 10 * C + C * (1 + t) + C / 2];
      check($sformatf("%s byte%0d", tag, j), b, exp_b[j]);
    end
  endtask

  // Line must stay idle (tx high, not busy, no done) over indices a..z.
  task automatic check_idle(input int a, input int z, input string tag);
    int err;
    wait_to(z + 2);
    err = 0;
    for (int i = a; i <= z; i++)
      if (tx_tr[i] !== 1'b1 || busy_tr[i] !== 1'b0 || done_tr[i] !== 1'b0) err++;
    check(tag, err, 0);
  endtask

  initial begin
    int s, s0, e, last_s, nfr;
    rst = 1'b1;
    req = 1'b0;
    set_inputs(16'h0, 8'h0, 8'h0, 16'h0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    wait_to(4);
    rst = 1'b0;
    wait_to(5);
    check("reset tx", tx_tr[3], 1);
    check("reset busy", busy_tr[3], 0);
    check("reset done", done_tr[3], 0);
    check_idle(4, 54, "idle after reset");

    // Directed frame with the reference values.
    set_inputs(16'h1234, 8'h05, 8'h03, 16'h00A0, 1'b1, 1'b1);
    model_frame(16'h1234, 8'h05, 8'h03, 16'h00A0, 1'b1, 1'b1);
    pulse_req(s);
    check_frame(s, "directed");
    check_idle(s + FLEN + 1, s + FLEN + 30, "idle after directed");

    // Inputs overwritten two cycles after capture, and a second req at byte 4.
    set_random_inputs();
    model_frame(delay, width, num_pulses, spacing, en, ready);
    pulse_req(s);
    wait_to(s + 2);
    set_inputs(16'hFFFF, 8'hFF, 8'hFF, 16'hFFFF, 1'b1, 1'b1);
    wait_to(s + 4 * 10 * C + 3 * C);
    req = 1'b1;
    @(posedge clk);
    #1;
    req = 1'b0;
    check_frame(s, "snapshot");
    check_idle(s + FLEN + 1, s + FLEN + 60, "ignored mid-frame req");

    // Random frames.
    for (int f = 0; f < 3; f++) begin
      set_random_inputs();
      model_frame(delay, width, num_pulses, spacing, en, ready);
      wait_to(cyc + 1 + $urandom_range(0, 7));
      pulse_req(s);
      check_frame(s, $sformatf("random%0d", f));
    end
    wait_to(cyc + 20);

    // req held high: back-to-back frames with a single idle cycle between.
    set_random_inputs();
    model_frame(delay, width, num_pulses, spacing, en, ready);
    s0 = cyc + 1;
    req = 1'b1;
    wait_to(s0 + 2500);
    req = 1'b0;
    nfr = 0;
    last_s = s0;
    for (int st = s0; st <= s0 + 2499; st += FLEN + 1) begin
      check_frame(st, $sformatf("held%0d", nfr));
      last_s = st;
      nfr++;
    end
    check("held frame count", nfr, (2499 / (FLEN + 1)) + 1);
    check_idle(last_s + FLEN + 1, last_s + FLEN + 50, "idle after held");

    // Reset during byte 3 bit 4, then a clean frame.
    set_random_inputs();
    pulse_req(s);
    e = s + 3 * 10 * C + 5 * C + 3;
    wait_to(e);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_idle(e, s + FLEN + 20, "after mid-frame reset");
    set_random_inputs();
    model_frame(delay, width, num_pulses, spacing, en, ready);
    pulse_req(s);
    check_frame(s, "post-reset");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
